// File: rtl/anti_theft_pkg.sv
// -----------------------------------------------------------------------------
// anti_theft_pkg
// Shared definitions for the anti-theft controller: FSM state encoding,
// time-parameter indices and their power-on default values (in seconds).
// -----------------------------------------------------------------------------
package anti_theft_pkg;

   typedef enum logic [2:0] {
      S_ARMED,
      S_TRIGGERED,
      S_ALARM_OPEN,
      S_ALARM_TIMED,
      S_DISARMED,
      S_DIS_WAIT_CLOSE,
      S_ARM_DELAY
   } state_e;

   typedef logic [1:0] param_sel_t;
   typedef logic [3:0] seconds_t;

   localparam param_sel_t P_ARM       = 2'd0;
   localparam param_sel_t P_DRIVER    = 2'd1;
   localparam param_sel_t P_PASSENGER = 2'd2;
   localparam param_sel_t P_ALARM     = 2'd3;

   localparam seconds_t T_ARM_DEFAULT       = 4'd6;
   localparam seconds_t T_DRIVER_DEFAULT    = 4'd8;
   localparam seconds_t T_PASSENGER_DEFAULT = 4'd15;
   localparam seconds_t T_ALARM_DEFAULT     = 4'd10;

   function automatic seconds_t default_value(input param_sel_t sel);
      seconds_t v;
      unique case (sel)
         P_ARM:       v = T_ARM_DEFAULT;
         P_DRIVER:    v = T_DRIVER_DEFAULT;
         P_PASSENGER: v = T_PASSENGER_DEFAULT;
         default:     v = T_ALARM_DEFAULT;
      endcase
      return v;
   endfunction

   // States in which the countdown timer is running.
   function automatic logic is_timed(input state_e s);
      return (s == S_TRIGGERED) || (s == S_ALARM_TIMED) || (s == S_ARM_DELAY);
   endfunction

endpackage

// File: rtl/time_param_regs.sv
// -----------------------------------------------------------------------------
// time_param_regs
// Four 4-bit time parameters with one synchronous write port and one
// combinational read port. Reset restores the default values.
//   clock      - system clock
//   reset      - asynchronous active-low reset
//   wr_en_i    - write strobe (one cycle)
//   wr_sel_i   - parameter index to write
//   wr_data_i  - value to write, seconds
//   rd_sel_i   - parameter index to read
//   rd_data_o  - selected parameter, combinational
// -----------------------------------------------------------------------------
module time_param_regs
   import anti_theft_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       wr_en_i,
   input  logic [1:0] wr_sel_i,
   input  logic [3:0] wr_data_i,
   input  logic [1:0] rd_sel_i,
   output logic [3:0] rd_data_o
);

   seconds_t param_q [4];

   // NOTE: this small storage array is deliberately reset, because the
   // defaults must come back on every reset; large RAMs normally are not.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            param_q[i] <= default_value(param_sel_t'(i));
         end
      end else if (wr_en_i) begin
         param_q[wr_sel_i] <= wr_data_i;
      end
   end

   assign rd_data_o = param_q[rd_sel_i];

endmodule

// File: rtl/anti_theft_fsm.sv
// -----------------------------------------------------------------------------
// anti_theft_fsm
// Control FSM of the automotive anti-theft system. Drives the countdown timer
// (start_timer/value), consumes its expired flag and 1 Hz / 2 Hz ticks, and
// drives the siren and status LED. All outputs are registered.
//   clock, reset (async, active-low)
//   ignition, door_driver, door_pass   - debounced switch inputs
//   reprogram, time_param_sel, time_value - parameter write port
//   expired, one_hz_enable, two_hz_enable - from the timer block
//   start_timer, value                 - to the timer block
//   siren, status_led                  - actuators
// -----------------------------------------------------------------------------
module anti_theft_fsm
   import anti_theft_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       ignition,
   input  logic       door_driver,
   input  logic       door_pass,
   input  logic       reprogram,
   input  logic [1:0] time_param_sel,
   input  logic [3:0] time_value,
   input  logic       expired,
   input  logic       one_hz_enable,
   input  logic       two_hz_enable,
   output logic       start_timer,
   output logic [3:0] value,
   output logic       siren,
   output logic       status_led
);

   state_e     state_q, state_d;
   logic       start_timer_q, start_timer_d;
   seconds_t   value_q, value_d;
   logic       siren_q, siren_d;
   logic       led_q, led_d;

   param_sel_t rd_sel;
   seconds_t   rd_data;
   logic       load_value;
   logic       timer_done;
   logic       any_door;
   logic       restart;

   time_param_regs u_params (
      .clock     (clock),
      .reset     (reset),
      .wr_en_i   (reprogram),
      .wr_sel_i  (time_param_sel),
      .wr_data_i (time_value),
      .rd_sel_i  (rd_sel),
      .rd_data_o (rd_data)
   );

   // A stale expired flag from the previous countdown is ignored until the
   // timer has seen our low start_timer cycle and been restarted.
   assign timer_done = expired & start_timer_q;
   assign any_door   = door_driver | door_pass;

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      rd_sel     = P_ARM;
      load_value = 1'b0;

      if (reprogram) begin
         state_d = S_ARMED;
      end else if (ignition) begin
         state_d = S_DISARMED;
      end else begin
         unique case (state_q)
            S_ARMED: begin
               if (door_driver) begin
                  state_d    = S_TRIGGERED;
                  rd_sel     = P_DRIVER;
                  load_value = 1'b1;
               end else if (door_pass) begin
                  state_d    = S_TRIGGERED;
                  rd_sel     = P_PASSENGER;
                  load_value = 1'b1;
               end
            end
            S_TRIGGERED: begin
               if (timer_done) begin
                  if (any_door) begin
                     state_d = S_ALARM_OPEN;
                  end else begin
                     state_d    = S_ALARM_TIMED;
                     rd_sel     = P_ALARM;
                     load_value = 1'b1;
                  end
               end
            end
            S_ALARM_OPEN: begin
               if (!any_door) begin
                  state_d    = S_ALARM_TIMED;
                  rd_sel     = P_ALARM;
                  load_value = 1'b1;
               end
            end
            S_ALARM_TIMED: begin
               // A reopened door wins over a simultaneous expiry.
               if (any_door) begin
                  state_d = S_ALARM_OPEN;
               end else if (timer_done) begin
                  state_d = S_ARMED;
               end
            end
            S_DISARMED: begin
               if (door_driver) begin
                  state_d = S_DIS_WAIT_CLOSE;
               end
            end
            S_DIS_WAIT_CLOSE: begin
               if (!door_driver) begin
                  state_d    = S_ARM_DELAY;
                  rd_sel     = P_ARM;
                  load_value = 1'b1;
               end
            end
            S_ARM_DELAY: begin
               if (door_driver) begin
                  state_d = S_DIS_WAIT_CLOSE;
               end else if (timer_done) begin
                  state_d = S_ARMED;
               end
            end
            default: state_d = S_ARMED;
         endcase
      end

      // Reprogram re-enters ARMED even from ARMED, so it counts as an entry.
      restart = reprogram || (state_d != state_q);

      value_d       = load_value ? rd_data : value_q;
      start_timer_d = is_timed(state_d) && !restart;
      siren_d       = (state_d == S_ALARM_OPEN) || (state_d == S_ALARM_TIMED);

      unique case (state_d)
         S_ARMED:       led_d = restart ? 1'b0 : (led_q ^ one_hz_enable);
         S_ARM_DELAY:   led_d = restart ? 1'b0 : (led_q ^ two_hz_enable);
         S_TRIGGERED,
         S_ALARM_OPEN,
         S_ALARM_TIMED: led_d = 1'b1;
         default:       led_d = 1'b0;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the values from before this clock edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= S_ARMED;
         start_timer_q <= 1'b0;
         value_q       <= '0;
         siren_q       <= 1'b0;
         led_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         start_timer_q <= start_timer_d;
         value_q       <= value_d;
         siren_q       <= siren_d;
         led_q         <= led_d;
      end
   end

   assign start_timer = start_timer_q;
   assign value       = value_q;
   assign siren       = siren_q;
   assign status_led  = led_q;

endmodule

// File: tb/tb_anti_theft_fsm.sv
// -----------------------------------------------------------------------------
// tb_anti_theft_fsm
// Directed bench for anti_theft_fsm. Expected output vectors
// {start_timer, value, siren, status_led} are queued as stimulus is applied
// and compared once the DUT has clocked.
// -----------------------------------------------------------------------------
module tb_anti_theft_fsm;

   logic       clock;
   logic       reset;
   logic       ignition;
   logic       door_driver;
   logic       door_pass;
   logic       reprogram;
   logic [1:0] time_param_sel;
   logic [3:0] time_value;
   logic       expired;
   logic       one_hz_enable;
   logic       two_hz_enable;
   logic       start_timer;
   logic [3:0] value;
   logic       siren;
   logic       status_led;

   typedef struct {
      string      tag;
      logic [6:0] vec;
   } exp_t;

   exp_t sb_q[$];
   int   checks_total;
   int   checks_passed;

   anti_theft_fsm dut (
      .clock          (clock),
      .reset          (reset),
      .ignition       (ignition),
      .door_driver    (door_driver),
      .door_pass      (door_pass),
      .reprogram      (reprogram),
      .time_param_sel (time_param_sel),
      .time_value     (time_value),
      .expired        (expired),
      .one_hz_enable  (one_hz_enable),
      .two_hz_enable  (two_hz_enable),
      .start_timer    (start_timer),
      .value          (value),
      .siren          (siren),
      .status_led     (status_led)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "bench timeout");
   end

   task automatic push(input string tag, input logic st, input logic [3:0] val,
                       input logic sir, input logic led);
      exp_t e;
      e.tag = tag;
      e.vec = {st, val, sir, led};
      sb_q.push_back(e);
   endtask

   task automatic drain();
      exp_t       e;
      logic [6:0] obs;
      while (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         obs = {start_timer, value, siren, status_led};
         checks_total++;
         assert (obs === e.vec) checks_passed++;
         else $error("FAIL %s: observed st/val/sir/led=%b/%h/%b/%b expected %b/%h/%b/%b",
                     e.tag, obs[6], obs[5:2], obs[1], obs[0],
                     e.vec[6], e.vec[5:2], e.vec[1], e.vec[0]);
      end
   endtask

   // Inputs hold across the coming edge; outputs are sampled 1 time unit after.
   task automatic cyc(input string tag, input logic st, input logic [3:0] val,
                      input logic sir, input logic led);
      push(tag, st, val, sir, led);
      @(posedge clock);
      #1;
      drain();
   endtask

   task automatic check_now(input string tag, input logic st, input logic [3:0] val,
                            input logic sir, input logic led);
      push(tag, st, val, sir, led);
      drain();
   endtask

   initial begin
      checks_total   = 0;
      checks_passed  = 0;
      reset          = 1'b1;
      ignition       = 1'b0;
      door_driver    = 1'b0;
      door_pass      = 1'b0;
      reprogram      = 1'b0;
      time_param_sel = 2'd0;
      time_value     = 4'd0;
      expired        = 1'b0;
      one_hz_enable  = 1'b0;
      two_hz_enable  = 1'b0;

      // Reset state
      #1 reset = 1'b0;
      @(posedge clock);
      #1;
      check_now("reset_outputs", 0, 4'd0, 0, 0);
      reset = 1'b1;

      // 1: ARMED idle, LED toggles on 1 Hz ticks
      cyc("armed_idle", 0, 4'd0, 0, 0);
      one_hz_enable = 1'b1;
      cyc("led_toggle_on", 0, 4'd0, 0, 1);
      one_hz_enable = 1'b0;
      cyc("led_hold", 0, 4'd0, 0, 1);
      one_hz_enable = 1'b1;
      cyc("led_toggle_off", 0, 4'd0, 0, 0);
      one_hz_enable = 1'b0;

      // 2: driver door -> TRIGGERED, expire closed -> ALARM_TIMED -> ARMED
      door_driver = 1'b1;
      cyc("trig_driver", 0, 4'd8, 0, 1);
      door_driver = 1'b0;
      cyc("trig_start", 1, 4'd8, 0, 1);
      expired = 1'b1;
      cyc("alarm_timed_entry", 0, 4'd10, 1, 1);
      expired = 1'b0;
      cyc("alarm_timed_start", 1, 4'd10, 1, 1);
      expired = 1'b1;
      cyc("alarm_expire_armed", 0, 4'd10, 0, 0);
      expired = 1'b0;

      // 3: both doors -> DRIVER wins; passenger only -> 15
      door_driver = 1'b1;
      door_pass   = 1'b1;
      cyc("both_doors_driver", 0, 4'd8, 0, 1);
      door_driver    = 1'b0;
      door_pass      = 1'b0;
      reprogram      = 1'b1;
      time_param_sel = 2'd0;
      time_value     = 4'd6;
      cyc("reprog_to_armed", 0, 4'd8, 0, 0);
      reprogram = 1'b0;
      door_pass = 1'b1;
      cyc("passenger_only", 0, 4'd15, 0, 1);
      door_pass = 1'b0;
      cyc("passenger_start", 1, 4'd15, 0, 1);

      // 4: ignition disarms mid-countdown; arm-delay with door reopen
      ignition = 1'b1;
      cyc("ignition_disarm", 0, 4'd15, 0, 0);
      ignition    = 1'b0;
      door_driver = 1'b1;
      cyc("dis_wait_close", 0, 4'd15, 0, 0);
      door_driver = 1'b0;
      cyc("arm_delay_entry", 0, 4'd6, 0, 0);
      cyc("arm_delay_start", 1, 4'd6, 0, 0);
      two_hz_enable = 1'b1;
      cyc("arm_delay_led", 1, 4'd6, 0, 1);
      two_hz_enable = 1'b0;
      door_driver   = 1'b1;
      cyc("door_reopen", 0, 4'd6, 0, 0);
      door_driver = 1'b0;
      cyc("reclose_reload", 0, 4'd6, 0, 0);
      cyc("reclose_start", 1, 4'd6, 0, 0);
      expired = 1'b1;
      cyc("arm_delay_expire", 0, 4'd6, 0, 0);
      expired = 1'b0;

      // 5: reprogram during ALARM_OPEN silences siren; new passenger value
      door_pass = 1'b1;
      cyc("t5_trig", 0, 4'd15, 0, 1);
      cyc("t5_start", 1, 4'd15, 0, 1);
      expired = 1'b1;
      cyc("alarm_open_entry", 0, 4'd15, 1, 1);
      expired = 1'b0;
      cyc("alarm_open_hold", 0, 4'd15, 1, 1);
      reprogram      = 1'b1;
      time_param_sel = 2'd2;
      time_value     = 4'd3;
      cyc("reprog_silence", 0, 4'd15, 0, 0);
      reprogram = 1'b0;
      cyc("new_passenger_val", 0, 4'd3, 0, 1);
      door_pass = 1'b0;
      cyc("new_passenger_start", 1, 4'd3, 0, 1);

      // 6: reprogram ARM=2, enter ARM_DELAY, stale expired ignored, async reset
      reprogram      = 1'b1;
      time_param_sel = 2'd0;
      time_value     = 4'd2;
      cyc("reprog_arm2", 0, 4'd3, 0, 0);
      reprogram = 1'b0;
      ignition  = 1'b1;
      cyc("t6_disarm", 0, 4'd3, 0, 0);
      ignition    = 1'b0;
      door_driver = 1'b1;
      cyc("t6_wait_close", 0, 4'd3, 0, 0);
      door_driver = 1'b0;
      cyc("arm_delay_prog2", 0, 4'd2, 0, 0);
      expired = 1'b1;
      cyc("expired_ignored", 1, 4'd2, 0, 0);
      expired = 1'b0;
      reset   = 1'b0;
      #1;
      check_now("async_reset_mid", 0, 4'd0, 0, 0);
      #3 reset = 1'b1;
      cyc("post_reset_armed", 0, 4'd0, 0, 0);
      one_hz_enable = 1'b1;
      cyc("post_reset_led", 0, 4'd0, 0, 1);
      one_hz_enable = 1'b0;
      ignition      = 1'b1;
      cyc("post_reset_disarm", 0, 4'd0, 0, 0);
      ignition    = 1'b0;
      door_driver = 1'b1;
      cyc("post_reset_wait", 0, 4'd0, 0, 0);
      door_driver = 1'b0;
      cyc("arm_default_restored", 0, 4'd6, 0, 0);
      cyc("arm_default_start", 1, 4'd6, 0, 0);
      expired = 1'b1;
      cyc("final_expire_armed", 0, 4'd6, 0, 0);
      expired = 1'b0;

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/anti_theft_fsm.md
Name: anti_theft_fsm

Overview:
Control FSM of the automotive anti-theft system. It sits directly upstream of the countdown timer block: it drives `start_timer` and the 4-bit `value`, and consumes `expired`, `one_hz_enable` and `two_hz_enable`. It owns the four reprogrammable time parameters, and drives the siren and the status LED. Switch inputs arrive already debounced and synchronised.

Parameters:
- T_ARM_DEFAULT, 6, arming delay in seconds after the driver leaves.
- T_DRIVER_DEFAULT, 8, grace period in seconds after the driver door opens while armed.
- T_PASSENGER_DEFAULT, 15, grace period in seconds after a passenger door opens while armed.
- T_ALARM_DEFAULT, 10, seconds the siren stays on after all doors close.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- ignition  in  1  ignition switch on
- door_driver  in  1  driver door open
- door_pass  in  1  any passenger door open
- reprogram  in  1  one-cycle write pulse
- time_param_sel  in  2  parameter to write: 0=ARM, 1=DRIVER, 2=PASSENGER, 3=ALARM
- time_value  in  4  new parameter value in seconds
- expired  in  1  timer countdown reached zero
- one_hz_enable  in  1  1 Hz tick, one cycle wide
- two_hz_enable  in  1  2 Hz tick, one cycle wide
- start_timer  out  1  level; high for the whole of a timed wait
- value  out  4  interval for the timer; stable while start_timer=1
- siren  out  1  siren drive
- status_led  out  1  status indicator

Behaviour:
- Reset (reset=0), asynchronous:
  - State = ARMED.
  - Parameters = defaults.
  - start_timer=0, value=0, siren=0, status_led=0.
- States: ARMED, TRIGGERED, ALARM_OPEN, ALARM_TIMED, DISARMED, DIS_WAIT_CLOSE, ARM_DELAY.
- Priority of events in any state:
  1. reprogram: write `time_value` into param[`time_param_sel`], go to ARMED.
  2. ignition=1: go to DISARMED.
  3. The door/expired transitions listed below.
- ARMED:
  - door_driver=1 → TRIGGERED, value=param[DRIVER].
  - Otherwise door_pass=1 → TRIGGERED, value=param[PASSENGER].
  - If both open in the same cycle, DRIVER wins.
- TRIGGERED: expired → ALARM_OPEN if any door is open, else → ALARM_TIMED.
- ALARM_OPEN: siren=1, timer idle. When all doors are closed → ALARM_TIMED, value=param[ALARM].
- ALARM_TIMED:
  - siren=1.
  - A door opening → ALARM_OPEN, which abandons the countdown.
  - expired → ARMED.
- DISARMED: ignition=0 and door_driver=1 → DIS_WAIT_CLOSE.
- DIS_WAIT_CLOSE: door_driver=0 → ARM_DELAY, value=param[ARM].
- ARM_DELAY:
  - door_driver=1 → DIS_WAIT_CLOSE, so the delay restarts after the next close.
  - expired → ARMED.
- Timer handshake:
  - start_timer is registered.
  - It is 0 in the first cycle of every timed state (TRIGGERED, ALARM_TIMED, ARM_DELAY), then 1 until the state is left.
  - Every state change therefore guarantees at least one low cycle, which restarts the timer and clears its expired flag.
  - `value` is loaded in the same cycle as the state entry.
  - expired is honoured only while start_timer=1; at any other time it is ignored.
  - In untimed states start_timer=0 and value holds its last value.
- Expiry with value=0: the timer expires on its first 1 Hz tick. Legal, not an error.
- status_led:
  - ARMED: toggles on each one_hz_enable (2 s period). Cleared to 0 on ARMED entry.
  - TRIGGERED, ALARM_OPEN, ALARM_TIMED: steady 1.
  - ARM_DELAY: toggles on two_hz_enable.
  - DISARMED, DIS_WAIT_CLOSE: 0.
- siren is registered. It is 1 only in ALARM_OPEN and ALARM_TIMED, and drops in the cycle the FSM leaves those states.
- Reset asserted mid-countdown: start_timer drops immediately (asynchronous), giving a clean return to ARMED.
- Reprogram while siren=1: the siren is silenced next cycle and the state goes to ARMED.
- Reprogram always writes the selected parameter; there are no invalid values.

Decomposition:
- Shared package `anti_theft_pkg`:
  - state enum.
  - parameter-index constants P_ARM, P_DRIVER, P_PASSENGER, P_ALARM.
  - 4-bit default values.
- Sub-module `time_param_regs`: 4×4-bit register file with one synchronous write port, a combinational read port selected by the FSM, and defaults applied on reset.
- The FSM, start_timer sequencing and LED/siren logic stay in the top module.

Test Plan:
1. Reset release, doors closed, ignition=0 → state ARMED, start_timer=0, siren=0; status_led toggles on every one_hz_enable.
2. ARMED, door_driver=1 → next cycle value=8, start_timer=0; cycle after, start_timer=1. Drive expired=1 with doors closed → ALARM_TIMED, siren=1, value=10, start_timer low 1 cycle then high; expired → ARMED, siren=0.
3. ARMED, door_pass=1 and door_driver=1 in the same cycle → value=8 (DRIVER wins). Repeat with door_pass only → value=15.
4. TRIGGERED with start_timer=1, ignition=1 → DISARMED next cycle, start_timer=0, status_led=0. Stimulus: ignition=0, door_driver 1 then 0 → ARM_DELAY, value=6. Reopen the door → DIS_WAIT_CLOSE, start_timer=0. Close → value=6 reloaded with a low gap; expired → ARMED.
5. Reprogram pulse, sel=2, time_value=3, during ALARM_OPEN → siren=0 next cycle, state ARMED. Open door_pass → value=3.
6. reset=0 asserted mid ARM_DELAY → start_timer=0 asynchronously. After release: state ARMED, param[ARM]=6 restored even if previously reprogrammed. Also check that expired=1 while start_timer=0 causes no transition.
